// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder:
//               FSM state encoding, word-offset width and wait-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Byte-offset bits inside a word (word = 4 bytes)
    localparam int c_OFFSET_W = 2;
    // Wait-state counter width, enough for WAIT_CYCLES up to 15
    localparam int c_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : Single-port word storage with per-byte-lane write strobes,
//               synchronous write and combinational read. Not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W      = $clog2(DEPTH_WORDS),
    localparam int LANES      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [LANES-1:0]  i_be,
    input  logic [IDX_W-1:0]  i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Update only the strobed byte lanes of the addressed word
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Target end of the MEM-stage load/store interface. Accepts one
//               request over valid/ready, waits WAIT_CYCLES, performs a word
//               read or write and returns a one-cycle response pulse with an
//               error flag for misaligned or out-of-range addresses.
//               Optional macro DMEM_BYTE_EN_EN adds the req_be lane strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_req_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_resp_err;
    logic                w_accept;
    logic                w_oor;
    logic                w_err;
    logic                w_wr_en;
    logic [LANES-1:0]    w_be;
    logic [DATA_W-1:0]   w_rdata;

    assign w_accept = req_valid && r_req_ready;

    // Any set address bit above the word index means the word is past the end
    generate
        if (ADDR_W > IDX_W + c_OFFSET_W) begin : g_oor_chk
            assign w_oor = |r_addr[ADDR_W-1:IDX_W+c_OFFSET_W];
        end else begin : g_oor_none
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_err   = (r_addr[c_OFFSET_W-1:0] != '0) || w_oor;
    assign w_wr_en = (r_state == ACCESS) && r_we && !w_err;

`ifdef DMEM_BYTE_EN_EN
    logic [LANES-1:0] r_be;

    // Lane strobe is captured together with the rest of the request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_be <= '0;
        end else if (w_accept) begin
            r_be <= req_be;
        end
    end

    assign w_be = r_be;
`else
    assign w_be = '1;
`endif

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_be    (w_be),
        .i_addr  (r_addr[IDX_W+c_OFFSET_W-1:c_OFFSET_W]),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    // FSM state register; reset drops any outstanding request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: IDLE -> [WAIT] -> ACCESS -> RESP -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == c_WAIT_LAST) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counting and registered response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= '0;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                ACCESS: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= w_err;
                    r_resp_rdata <= (!r_we && !w_err) ? w_rdata : '0;
                end
                RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A word-array model
//               predicts load data, error flags and response timing for
//               directed and randomized requests.
//               Honours DMEM_BYTE_EN_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;
`ifdef DMEM_BYTE_EN_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  req_be = 4'hF;
`endif
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_m [DEPTH];
    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_EN_EN
        .req_be     (req_be),
`endif
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= DEPTH);
    endfunction

    // One complete transaction; entered and left at a negedge in IDLE
    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  m;
        int          lat;
        exp_err = addr_bad(addr);
        exp_rd  = (!we && !exp_err) ? mem_m[addr / 4] : 32'h0;
        m = 4'hF;
        if (BE_EN) m = be;
        chk("idle_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
`ifdef DMEM_BYTE_EN_EN
        req_be = be;
`endif
        @(negedge clk);
        chk("busy_ready", {31'b0, req_ready}, 32'd0);
        // Junk on the inputs while busy must be ignored
        req_valid = 1'($urandom); req_we = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        for (int n = 1; n <= W + 6; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n;
                break;
            end
        end
        chk("resp_latency", lat, W + 1);
        req_valid = 1'b0;
        if (lat != 0) begin
            chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
            chk("resp_rdata", resp_rdata, exp_rd);
            @(negedge clk);
            chk("pulse_end", {31'b0, resp_valid}, 32'd0);
            chk("ready_back", {31'b0, req_ready}, 32'd1);
        end
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) mem_m[addr / 4][b*8 +: 8] = wd[b*8 +: 8];
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7)       return {22'b0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
        else if (sel == 7) return {22'b0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
        else if (sel == 8) return ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
        else               return $urandom;
    endfunction

    initial begin
        logic [31:0] old;
        logic [31:0] q[$];
        int k, nr, low, seen;

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'b0, resp_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Idle with req_valid low: nothing happens
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || !req_ready) seen++;
        end
        chk("idle_quiet", seen, 0);

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) xact(1'b1, i * 4, $urandom, 4'hF);

        // Directed cases
        xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        xact(1'b0, 32'h10, 32'h0, 4'hF);
        xact(1'b0, 32'h13, 32'h0, 4'hF);
        xact(1'b0, 32'h10, 32'h0, 4'hF);
        xact(1'b1, 32'h400, 32'h1234_5678, 4'hF);
        xact(1'b0, 32'h3FC, 32'h0, 4'hF);
        xact(1'b0, 32'h0, 32'h0, 4'hF);

`ifdef DMEM_BYTE_EN_EN
        xact(1'b1, 32'h40, 32'h1111_1111, 4'hF);
        xact(1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101);
        xact(1'b0, 32'h40, 32'h0, 4'h0);
        chk("be_merge_model", mem_m[16], 32'h11BB_11DD);
        xact(1'b1, 32'h40, 32'h5555_5555, 4'b0000);
        xact(1'b0, 32'h40, 32'h0, 4'hF);
`endif

        // Streaming: req_valid held high, address incrementing
        k = 0; nr = 0; low = 0;
        req_we = 1'b0; req_valid = 1'b1; req_addr = 32'h100;
        for (int c = 0; c < 200 && nr < 6; c++) begin
            if (resp_valid) begin
                chk("stream_rdata", resp_rdata, (q.size() > 0) ? q.pop_front() : 32'hBAD0_BAD0);
                chk("stream_err", {31'b0, resp_err}, 32'd0);
                nr++;
            end
            if (req_ready && k < 6) begin
                if (k > 0) chk("stream_busy_len", low, W + 2);
                req_addr = 32'h100 + 4 * k;
                q.push_back(mem_m[(32'h100 + 4 * k) / 4]);
                k++;
                low = 0;
            end else begin
                if (!req_ready) low++;
                req_valid = (k < 6);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("stream_count", nr, 6);
        chk("stream_extra", seen, 0);
        chk("stream_left", q.size(), 0);

        // Reset during WAIT of a store drops it
        old = mem_m[8];
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = ~old;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_valid", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("midrst_no_resp", seen, 0);
        xact(1'b0, 32'h20, 32'h0, 4'hF);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            xact(1'($urandom), rand_addr(), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        end

        // Read back a sample of the array against the model
        for (int i = 0; i < 16; i++) xact(1'b0, 32'($urandom_range(0, DEPTH - 1)) * 4, 32'h0, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
